// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program counter for the SAYEH datapath
//
// Holds the current program counter. It supports increment, PC-relative
// branch, absolute load, and call/return through an internal return-address
// stack (RAS). All state changes on the falling edge of clk. There is no
// combinational path from any input to any output.
//
// Ports:
//   clk          clock; state updates on the falling edge
//   rst          synchronous active-high reset, sampled on the falling edge
//   enable       when low, all state holds
//   op           operation select:
//                  000 HOLD, 001 INC, 010 REL, 011 LOAD, 100 CALL, 101 RET,
//                  110/111 reserved (act as HOLD)
//   target       absolute LOAD/CALL destination
//   offset       signed REL offset, relative to the current pc
//   pc           current program counter (registered)
//   stack_empty  RAS holds no entries
//   stack_full   RAS holds STACK_DEPTH entries
//   stack_count  number of valid RAS entries
//   stack_err    sticky overflow/underflow flag, cleared only by rst
//
// Build option:
//   PC_STACK_WRAP_EN  when defined, the RAS is circular. A CALL on a full
//                     stack overwrites the oldest entry and does not set
//                     stack_err. When undefined, a CALL on a full stack
//                     still jumps, but the push is dropped and stack_err
//                     is set.
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int               WIDTH        = 16,
    parameter int               OFFSET_W     = 8,
    parameter int               STACK_DEPTH  = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [2:0]                         op,
    input  logic [WIDTH-1:0]                   target,
    input  logic [OFFSET_W-1:0]                offset,
    output logic [WIDTH-1:0]                   pc,
    output logic                               stack_empty,
    output logic                               stack_full,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
    output logic                               stack_err
);

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int PW = $clog2(STACK_DEPTH);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_REL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;

    logic [WIDTH-1:0] ras [STACK_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    ptr_up;
    logic [PW-1:0]    ptr_dn;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] offset_ext;
    logic             do_push;
    logic             do_pop;
    logic             set_err;

    // The RAS is a circular buffer. wr_ptr is the next free slot, so the
    // top of the stack sits one slot below it. The same pointer scheme is
    // used in both builds. Only the wrap build ever pushes while full,
    // and in that case wr_ptr already points at the oldest entry.
    assign ptr_up = (wr_ptr == PW'(STACK_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    assign ptr_dn = (wr_ptr == '0) ? PW'(STACK_DEPTH - 1) : wr_ptr - PW'(1);

    assign pc_inc     = pc + WIDTH'(1);
    assign offset_ext = WIDTH'($signed(offset));

    assign stack_empty = (stack_count == '0);
    assign stack_full  = (stack_count == CW'(STACK_DEPTH));

    // Decode the stack side effects of the current op.
    // A RET on an empty stack falls back to INC and flags an underflow.
    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_err = 1'b0;
        if (enable && !rst) begin
            case (op)
                OP_CALL: begin
                    if (!stack_full) begin
                        do_push = 1'b1;
                    end else begin
`ifdef PC_STACK_WRAP_EN
                        do_push = 1'b1;
`else
                        set_err = 1'b1;
`endif
                    end
                end
                OP_RET: begin
                    if (stack_empty)
                        set_err = 1'b1;
                    else
                        do_pop = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Program counter, stack pointer, count and sticky error.
    // The count saturates at STACK_DEPTH when a push overwrites on a full
    // stack, but the pointer still advances.
    always_ff @(negedge clk) begin
        if (rst) begin
            pc          <= RESET_VECTOR;
            wr_ptr      <= '0;
            stack_count <= '0;
            stack_err   <= 1'b0;
        end else if (enable) begin
            case (op)
                OP_HOLD: pc <= pc;
                OP_INC:  pc <= pc_inc;
                OP_REL:  pc <= pc + offset_ext;
                OP_LOAD: pc <= target;
                OP_CALL: pc <= target;
                OP_RET:  pc <= stack_empty ? pc_inc : ras[ptr_dn];
                default: pc <= pc;
            endcase

            if (do_push)
                wr_ptr <= ptr_up;
            else if (do_pop)
                wr_ptr <= ptr_dn;

            if (do_push && !stack_full)
                stack_count <= stack_count + CW'(1);
            else if (do_pop)
                stack_count <= stack_count - CW'(1);

            if (set_err)
                stack_err <= 1'b1;
        end
    end

    // RAS storage has no reset. Entries become meaningful only through the
    // count and pointer.
    always_ff @(negedge clk) begin
        if (do_push)
            ras[wr_ptr] <= pc_inc;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the SAYEH datapath.
- Adds in-block increment, PC-relative branch, absolute jump, and call/return through an internal return-address stack (RAS) alongside the plain load-when-enabled behaviour.
- Sits between the controller (which supplies op/enable) and the address-bus mux.
- All state is registered; the current PC is driven to memory addressing.

Parameters:
- WIDTH, 16, PC and address width in bits.
- OFFSET_W, 8, width of signed relative-branch offset (two's complement, OFFSET_W <= WIDTH).
- STACK_DEPTH, 8, number of RAS entries (>= 2).
- RESET_VECTOR, 0, PC value after reset.

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- rst  input  1  synchronous active-high reset, sampled on the falling edge of clk.
- enable  input  1  when low, all state (PC, stack, flags) holds.
- op  input  3  operation select (see Behaviour).
- target  input  WIDTH  absolute jump/call destination.
- offset  input  OFFSET_W  signed branch offset.
- pc  output  WIDTH  current program counter (registered).
- stack_empty  output  1  RAS holds 0 entries.
- stack_full  output  1  RAS holds STACK_DEPTH entries.
- stack_count  output  $clog2(STACK_DEPTH+1)  number of valid RAS entries.
- stack_err  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (rst=1 at a falling edge, enable ignored):
  - pc=RESET_VECTOR, stack_count=0, stack_empty=1, stack_full=0, stack_err=0.
  - RAS contents are don't-care.
  - Reset mid-sequence discards any pending stack contents.
- Outputs change only at falling edges; no combinational path from inputs to outputs.
- With enable=1, op is decoded at each falling edge:
  - 000 HOLD: pc unchanged.
  - 001 INC: pc <= pc+1.
  - 010 REL: pc <= pc + sign_extend(offset). Offset is relative to the current pc, not pc+1.
  - 011 LOAD: pc <= target.
  - 100 CALL: push pc+1 onto RAS; pc <= target.
  - 101 RET: pc <= top of RAS; pop.
  - 110, 111: reserved, behave as HOLD; no flag change.
- Arithmetic is modulo 2^WIDTH:
  - INC from all-ones wraps to 0.
  - REL wraps in both directions.
  - A pushed return address of all-ones+1 is 0.
- RAS is LIFO; stack_count is updated in the same edge as pc.
- CALL when stack_full=1 (STACK_WRAP_EN undefined):
  - Jump still taken.
  - Push suppressed; stack contents and count unchanged.
  - stack_err <= 1.
- RET when stack_empty=1:
  - pc <= pc+1 (treated as INC).
  - Count stays 0; stack_err <= 1.
- stack_err is sticky; only rst clears it.
- No op pushes and pops in the same edge; CALL is one push, RET is one pop.
- stack_full and stack_empty are derived from the registered count.
- enable=0 with any op: no change to any state, including stack_err.

Optional Feature:
- Macro: PC_STACK_WRAP_EN.
- Defined: RAS is circular.
  - CALL on full overwrites the oldest entry; stack_count stays STACK_DEPTH; stack_err is not set by overflow.
  - RET-on-empty behaviour and underflow error are unchanged.
- Undefined: overflow behaviour exactly as in Behaviour (push suppressed, stack_err set).

Test Plan:
- Reset with enable=0, op=001 → pc=RESET_VECTOR (0x0000), stack_empty=1, stack_count=0, stack_err=0 after one falling edge.
- pc=0x0010: INC → 0x0011; REL offset=0xFE (−2) → 0x000F; LOAD target=0xFFFF → 0xFFFF; INC → 0x0000 (wrap).
- pc=0x0100: CALL target=0x0200 → pc=0x0200, count=1; CALL target=0x0300 → pc=0x0300, count=2; RET → pc=0x0201; RET → pc=0x0101, stack_empty=1.
- Eight CALLs (STACK_DEPTH=8) → stack_full=1; ninth CALL target=0x0A00 → pc=0x0A00, count=8, stack_err=1 (wrap build: stack_err=0, and eight RETs return the addresses pushed by CALLs 2-9).
- RET on empty at pc=0x0050 → pc=0x0051, stack_err=1; next INC keeps stack_err=1 until rst.
- enable=0 with op=100 target=0x1234 for 3 edges → pc, stack_count, flags unchanged; rst asserted with count=3 → count=0 and pc=RESET_VECTOR on the same edge.
